// File: rtl/adder_lane_pipe.sv
// Two-stage valid/ready adder bank: bitwise half-add, per-lane add, or one chained wide add.
// Define ADDER_SAT_EN to make modes 1/2 saturate to all-ones on carry-out.

module adder_lane #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             co,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);
  logic [WIDTH:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign co  = raw[WIDTH];

  always_comb begin
    sum  = a ^ b;
    cout = a & b;
    case (mode)
      2'd1: begin
`ifdef ADDER_SAT_EN
        sum = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
        sum = raw[WIDTH-1:0];
`endif
        cout = {{(WIDTH-1){1'b0}}, raw[WIDTH]};
      end
      // chained: carry leaves through co, wide saturation is decided at the top
      2'd2: begin
        sum  = raw[WIDTH-1:0];
        cout = '0;
      end
      default: ;
    endcase
  end
endmodule

module adder_lane_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [LANES-1:0]       cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] sum,
  output logic [LANES*WIDTH-1:0] cout
);
  typedef struct packed {
    logic [1:0]                   mode;
    logic [LANES-1:0][WIDTH-1:0]  a;
    logic [LANES-1:0][WIDTH-1:0]  b;
    logic [LANES-1:0]             cin;
  } req_t;

  typedef struct packed {
    logic [LANES-1:0][WIDTH-1:0]  sum;
    logic [LANES-1:0][WIDTH-1:0]  cout;
  } rsp_t;

  req_t                        s1;
  rsp_t                        s2, nxt;
  logic [2:1]                  vld_pipe;
  logic                        s2_load, in_fire, wide_co;
  logic [LANES-1:0][WIDTH-1:0] lane_sum, lane_cout;

  assign s2_load  = vld_pipe[1] && (!vld_pipe[2] || out_ready);
  assign in_ready = !vld_pipe[1] || s2_load;
  assign in_fire  = in_valid && in_ready;

  // Lane l takes its own cin in mode 1, otherwise the carry rippling out of lane l-1.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic ci, co;
    if (l == 0) begin : g_first
      assign ci = s1.cin[0];
    end else begin : g_rest
      assign ci = (s1.mode == 2'd1) ? s1.cin[l] : g_lane[l-1].co;
    end
    adder_lane #(.WIDTH(WIDTH)) u_lane (
      .mode (s1.mode),
      .a    (s1.a[l]),
      .b    (s1.b[l]),
      .ci   (ci),
      .co   (co),
      .sum  (lane_sum[l]),
      .cout (lane_cout[l])
    );
  end

  assign wide_co = g_lane[LANES-1].co;

  always_comb begin
    nxt.sum  = lane_sum;
    nxt.cout = lane_cout;
    if (s1.mode == 2'd2) begin
      nxt.cout[0][0] = wide_co;
`ifdef ADDER_SAT_EN
      if (wide_co) nxt.sum = '1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (in_fire) begin
        s1.mode <= mode;
        s1.a    <= a;
        s1.b    <= b;
        s1.cin  <= cin;
      end
      if (s2_load) s2 <= nxt;
      vld_pipe[1] <= in_fire || (vld_pipe[1] && !s2_load);
      vld_pipe[2] <= s2_load || (vld_pipe[2] && !out_ready);
    end
  end

  assign out_valid = vld_pipe[2];
  assign sum       = s2.sum;
  assign cout      = s2.cout;
endmodule

// File: tb/tb_adder_lane_pipe.sv
// Scoreboard bench for adder_lane_pipe (WIDTH=8, LANES=4): directed vectors, streaming,
// backpressure and mid-flight reset.
module tb_adder_lane_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [1:0]  mode = 2'd0;
  logic [31:0] a = '0, b = '0, sum, cout;
  logic [3:0]  cin = '0;

  always #5 clk = ~clk;

  adder_lane_pipe #(.WIDTH(8), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a, b;
    logic [3:0]  cin;
    logic [31:0] s, c;
  } vec_t;

  typedef struct {
    logic [31:0] s, c;
    int          cyc;
    bit          lat;
  } exp_t;

`ifdef ADDER_SAT_EN
  localparam logic [31:0] T2S = 32'h81FF31FF, T3BS = 32'hFFFFFFFF, FFS = 32'hFFFFFFFF;
`else
  localparam logic [31:0] T2S = 32'h81003100, T3BS = 32'h00000000, FFS = 32'h00000000;
`endif

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[8];
  int   checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Holds the beat until accepted; the expectation is queued on the accepting edge.
  task automatic send(input vec_t v, input bit lat);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1; mode = v.mode; a = v.a; b = v.b; cin = v.cin;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = v.s; e.c = v.c; e.cyc = cyc; e.lat = lat;
        sb.push_back(e);
        ok = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge clk);
    chk("drain_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic vec_t strm(input int i, input logic [7:0] base);
    vec_t        v;
    logic [7:0]  x;
    x      = base + 8'(i);
    v.mode = 2'd1;
    v.a    = {4{x}};
    v.b    = 32'h10101010;
    v.cin  = 4'h0;
    v.s    = {4{x + 8'h10}};
    v.c    = 32'h0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got sum %h cout %h, want no beat", sum, cout);
      end else begin
        mon_e = sb.pop_front();
        chk("sum", sum, mon_e.s);
        chk("cout", cout, mon_e.c);
        if (mon_e.lat) chk("latency", cyc - mon_e.cyc, 32'd2);
      end
    end
  end

  initial begin
    vt[0] = '{2'd0, 32'hF0F000FF, 32'hFF000F0F, 4'h0, 32'h0FF00FF0, 32'hF000000F};
    vt[1] = '{2'd1, 32'h7F8010FF, 32'h01802001, 4'hA, T2S,          32'h00010001};
    vt[2] = '{2'd2, 32'h000000FF, 32'h00000001, 4'hF, 32'h00000101, 32'h00000000};
    vt[3] = '{2'd3, 32'h12345678, 32'h0F0F0F0F, 4'hF, 32'h1D3B5977, 32'h02040608};
    vt[4] = '{2'd1, 32'hFFFFFFFF, 32'h00000000, 4'hF, FFS,          32'h01010101};
    vt[5] = '{2'd2, 32'hFFFFFFFF, 32'h00000001, 4'h0, T3BS,         32'h00000001};
    vt[6] = '{2'd0, 32'hAAAA5555, 32'hFFFF0000, 4'h5, 32'h55555555, 32'hAAAA0000};
    vt[7] = '{2'd2, 32'h00FFFFFF, 32'h00000001, 4'hE, 32'h01000000, 32'h00000000};

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", cout, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // isolated beats into an idle pipe
    foreach (vt[i]) begin
      send(vt[i], 1'b1);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
    drain();

    // same vectors back-to-back, modes switching every beat
    foreach (vt[i]) send(vt[i], 1'b1);
    in_valid = 1'b0;
    drain();

    // 8-beat stream at full rate
    for (int i = 0; i < 8; i++) send(strm(i, 8'h00), 1'b1);
    in_valid = 1'b0;
    drain();

    // backpressure: beat 1 sits in stage 2, beat 2 in stage 1 during the stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(strm(i, 8'h40), 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_sum", sum, 32'h51515151);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with two beats in flight
    send(strm(0, 8'h60), 1'b1);
    send(strm(1, 8'h60), 1'b1);
    in_valid = 1'b0;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_sum", sum, 32'd0);
    chk("async_rst_cout", cout, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(strm(2, 8'h60), 1'b1);
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
